// File: rtl/tile_bus_responder.sv
// Slot-side target for the Dock I/O bus: answers /CS cycles with programmable wait states,
// serves a 4-entry register file and vector fetches, and raises level interrupt requests.
module tile_bus_responder #(
  parameter int          NUM_CH   = 2,
  parameter int          WAIT_CYC = 1,
  parameter logic [7:0]  SPUR_VEC = 8'hFF,
  parameter int          REG_AW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              io_r_w_,
  input  logic [REG_AW-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic              rdata_oe,
  output logic              ready_n,
  input  logic              slot_ack,
  input  logic [NUM_CH-1:0] evt,
  output logic [NUM_CH-1:0] int_req
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  localparam logic [3:0] CNT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              served;
  logic              cs_n_q;
  logic [NUM_CH-1:0] ie;
  logic [NUM_CH-1:0] pend;
  logic [7:0]        vec_base;
  logic [7:0]        scratch;

  logic              start;
  logic              act;
  logic [7:0]        reg_rd;
  logic              vec_hit;
  logic [2:0]        vec_ch;
  logic [NUM_CH-1:0] vec_sel;
  logic [NUM_CH-1:0] clr;
  logic [NUM_CH-1:0] pend_next;

  // Bus handshake: a cycle starts on a registered falling edge of cs_n; ready_n drops
  // together with valid rdata/rdata_oe one edge after READY is entered, and both stay
  // until cs_n rises. Any cs_n high returns the FSM to IDLE on the next edge.
  always_comb begin
    start  = cs_n_q && !cs_n;
    act    = (state == S_READY) && !served && !cs_n;

    reg_rd = '0;
    if (addr == REG_AW'(0))      reg_rd[NUM_CH-1:0] = ie;
    else if (addr == REG_AW'(1)) reg_rd[NUM_CH-1:0] = pend;
    else if (addr == REG_AW'(2)) reg_rd = vec_base;
    else                         reg_rd = scratch;

    vec_hit = 1'b0;
    vec_ch  = 3'd0;
    vec_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!vec_hit && pend[i] && ie[i]) begin
        vec_hit    = 1'b1;
        vec_ch     = 3'(i);
        vec_sel[i] = 1'b1;
      end
    end

    clr = '0;
    if (act && !io_r_w_ && addr == REG_AW'(1)) clr = wdata[NUM_CH-1:0];
    if (act && io_r_w_ && slot_ack)            clr = vec_sel;

    // A new event outranks a clear of the same bit in the same cycle.
    pend_next = (pend & ~clr) | evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      served   <= 1'b0;
      cs_n_q   <= 1'b0;
      ie       <= '0;
      pend     <= '0;
      vec_base <= '0;
      scratch  <= '0;
      rdata    <= '0;
      rdata_oe <= 1'b0;
      ready_n  <= 1'b1;
      int_req  <= '0;
    end else begin
      cs_n_q  <= cs_n;
      pend    <= pend_next;
      int_req <= pend & ie;
      if (cs_n) begin
        state    <= S_IDLE;
        served   <= 1'b0;
        ready_n  <= 1'b1;
        rdata_oe <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            served <= 1'b0;
            if (start) begin
              if (WAIT_CYC == 0) begin
                state <= S_READY;
              end else begin
                state <= S_WAIT;
                cnt   <= CNT_LOAD;
              end
            end
          end
          S_WAIT: begin
            if (cnt == 4'd0) state <= S_READY;
            else             cnt   <= cnt - 4'd1;
          end
          S_READY: begin
            if (!served) begin
              served  <= 1'b1;
              ready_n <= 1'b0;
              if (!io_r_w_) begin
                if (addr == REG_AW'(0))      ie       <= wdata[NUM_CH-1:0];
                else if (addr == REG_AW'(2)) vec_base <= wdata;
                else if (addr == REG_AW'(3)) scratch  <= wdata;
              end else begin
                rdata_oe <= 1'b1;
                if (!slot_ack)    rdata <= reg_rd;
                else if (vec_hit) rdata <= vec_base + 8'(vec_ch);
                else              rdata <= SPUR_VEC;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
